// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM port arbiter: controller states and the
// inactive (deasserted) levels of the macro's active-low control pins.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WR_ISSUE   = 3'd1,
        RD_ISSUE   = 3'd2,
        RD_CAPTURE = 3'd3,
        RSP        = 3'd4
    } state_t;

    localparam logic CSB_IDLE = 1'b1;
    localparam logic WEB_IDLE = 1'b1;
    localparam logic OEB_IDLE = 1'b1;

endpackage

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - highest-priority index for this decision
//   grant - one-hot grant (zero when req is zero)
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned PW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] pick;

    // Prefer requests at or above ptr; otherwise wrap to the lowest request.
    // Isolate the lowest set bit of the chosen vector with x & -x.
    always_comb begin
        mask   = {NUM_REQ{1'b1}} << ptr;
        masked = req & mask;
        pick   = (|masked) ? masked : req;
        grant  = pick & (~pick + NUM_REQ'(1));
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous single-port SRAM macro between NUM_REQ requesters,
// one operation in flight, round-robin arbitration, owns the tri-state bus.
// Ports:
//   clk, rst                   - clock shared with the macro, sync active-high reset
//   req_valid/ready/we/addr/wdata - per-requester request handshake (addr/wdata packed)
//   rsp_valid/ready, rsp_data  - per-requester read response, shared data
//   sram_addr/csb/web/oeb      - registered macro control pins (active-low controls)
//   sram_data                  - macro data bus, driven only while issuing a write
module sram_port_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 2,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned NUM_REQ    = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    input  logic [NUM_REQ-1:0]               rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic [ADDR_WIDTH-1:0]            sram_addr,
    inout  wire  [DATA_WIDTH-1:0]            sram_data,
    output logic                             sram_csb,
    output logic                             sram_web,
    output logic                             sram_oeb
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    state_t                  state;
    state_t                  state_nx;
    logic [PW-1:0]           rr_ptr;
    logic [PW-1:0]           owner;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [NUM_REQ-1:0]      grant;
    logic                    accept;
    logic                    csb_nx;
    logic                    web_nx;
    logic                    oeb_nx;

    logic [PW-1:0]           sel_idx;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Index and request fields of the granted requester.
    always_comb begin
        sel_idx   = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant[i]) begin
                sel_idx   = PW'(i);
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next state, request handshake, and pin levels for the state being entered.
    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        req_ready = '0;
        csb_nx    = CSB_IDLE;
        web_nx    = WEB_IDLE;
        oeb_nx    = OEB_IDLE;
        case (state)
            IDLE: begin
                if (!rst) begin
                    req_ready = grant;
                    if (|grant) begin
                        accept   = 1'b1;
                        state_nx = sel_we ? WR_ISSUE : RD_ISSUE;
                    end
                end
            end
            WR_ISSUE:   state_nx = IDLE;
            RD_ISSUE:   state_nx = RD_CAPTURE;
            RD_CAPTURE: state_nx = RSP;
            RSP:        if (rsp_ready[owner]) state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
        case (state_nx)
            WR_ISSUE: begin
                csb_nx = 1'b0;
                web_nx = 1'b0;
            end
            RD_ISSUE, RD_CAPTURE: begin
                csb_nx = 1'b0;
                oeb_nx = 1'b0;
            end
            default: ;
        endcase
    end

    // State, latched request, pin registers and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            wdata_q   <= '0;
            sram_addr <= '0;
            sram_csb  <= CSB_IDLE;
            sram_web  <= WEB_IDLE;
            sram_oeb  <= OEB_IDLE;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            state    <= state_nx;
            sram_csb <= csb_nx;
            sram_web <= web_nx;
            sram_oeb <= oeb_nx;
            if (accept) begin
                owner     <= sel_idx;
                sram_addr <= sel_addr;
                wdata_q   <= sel_wdata;
                rr_ptr    <= (sel_idx == PW'(NUM_REQ - 1)) ? '0 : sel_idx + PW'(1);
            end
            rsp_valid <= (state_nx == RSP) ? (NUM_REQ'(1) << owner) : '0;
            // The macro presents the word during RD_CAPTURE; grab it on the closing edge.
            if (state == RD_CAPTURE) rsp_data <= sram_data;
        end
    end

    assign sram_data = (state == WR_ISSUE) ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule
